mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register and writeback stage of the pipelined RV32I core.

---
 rtl/mem_wb_if.sv | 49 ++++
 rtl/mem_wb_stage.sv | 109 ++++++++++
 tb/tb_mem_wb_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-stage results and control in, register file write port out.
// Optional feature macro: WB_INSTRET_EN (adds the 64-bit retired-instruction count).
//
// Handshake: there is no valid/ready pair. The stage samples every MEM-side
// signal on each rising clk edge unless Stall holds it or Flush bubbles it.
// MemValid marks a real instruction. WbValid marks a real instruction in WB.
interface mem_wb_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  Stall;
  logic                  Flush;
  logic                  MemValid;
  logic                  MemRegWrite;
  logic [REG_ADDR_W-1:0] MemRd;
  logic [1:0]            MemToReg;
  logic [2:0]            MemFunct3;
  logic [XLEN-1:0]       MemAluResult;
  logic [XLEN-1:0]       MemPcPlus4;
  logic [XLEN-1:0]       MemLoadWord;

  logic                  WbValid;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteRegNum;
  logic [XLEN-1:0]       WriteRegData;
`ifdef WB_INSTRET_EN
  logic [63:0]           Instret;
`endif

  // MEM-stage side: drives the stage inputs and observes the write port.
  modport master (
    output Stall, Flush, MemValid, MemRegWrite, MemRd, MemToReg, MemFunct3,
           MemAluResult, MemPcPlus4, MemLoadWord,
`ifdef WB_INSTRET_EN
    input  Instret,
`endif
    input  WbValid, RegWrite, WriteRegNum, WriteRegData
  );

  // The MEM/WB stage itself.
  modport slave (
    input  Stall, Flush, MemValid, MemRegWrite, MemRd, MemToReg, MemFunct3,
           MemAluResult, MemPcPlus4, MemLoadWord,
`ifdef WB_INSTRET_EN
    output Instret,
`endif
    output WbValid, RegWrite, WriteRegNum, WriteRegData
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage of the RV32I core.
// It aligns and extends load data, selects the writeback value, and registers
// the register file write port. The write port is driven straight from flops,
// so the register file bypass sees outputs that do not glitch.
// Optional feature macro: WB_INSTRET_EN (64-bit retired-instruction counter).
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic  clk,
  input  logic  rst,
  mem_wb_if.slave bus
);

  logic [1:0]            w_off;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_data;
  logic [XLEN-1:0]       w_wb_data;
  logic                  w_write_en;
  logic                  w_load_edge;

  logic                  r_valid;
  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;

  assign w_off = bus.MemAluResult[1:0];

  // Pick the addressed byte and halfword out of the aligned memory word.
  // off[0] is ignored for halfwords; misaligned accesses are not trapped here.
  always_comb begin
    w_byte = bus.MemLoadWord[7:0];
    case (w_off)
      2'd0:    w_byte = bus.MemLoadWord[7:0];
      2'd1:    w_byte = bus.MemLoadWord[15:8];
      2'd2:    w_byte = bus.MemLoadWord[23:16];
      default: w_byte = bus.MemLoadWord[31:24];
    endcase
    w_half = w_off[1] ? bus.MemLoadWord[31:16] : bus.MemLoadWord[15:0];
  end

  // Extend the load to XLEN from funct3. Undefined encodings pass the word through.
  always_comb begin
    w_load_data = bus.MemLoadWord;
    case (bus.MemFunct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = bus.MemLoadWord;
    endcase
  end

  // Writeback source select: 01 load, 10 link value, 00 or 11 ALU result.
  always_comb begin
    w_wb_data = bus.MemAluResult;
    case (bus.MemToReg)
      2'b01:   w_wb_data = w_load_data;
      2'b10:   w_wb_data = bus.MemPcPlus4;
      default: w_wb_data = bus.MemAluResult;
    endcase
  end

  // Decide the write enable before the flop. x0 and bubbles never write.
  assign w_write_en  = bus.MemValid & bus.MemRegWrite & (bus.MemRd != '0);
  assign w_load_edge = ~bus.Flush & ~bus.Stall;

  // Pipeline register. Priority is reset, then flush, then stall, then load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
    end else if (bus.Flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
    end else if (w_load_edge) begin
      r_valid    <= bus.MemValid;
      r_regwrite <= w_write_en;
      r_rd       <= bus.MemRd;
      r_data     <= w_wb_data;
    end
  end

  assign bus.WbValid      = r_valid;
  assign bus.RegWrite     = r_regwrite;
  assign bus.WriteRegNum  = r_rd;
  assign bus.WriteRegData = r_data;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Count each edge that loads a real instruction. The counter wraps naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (w_load_edge && bus.MemValid) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign bus.Instret = r_instret;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed spec cases plus randomized traffic checked
// against a behavioural model of the writeback rules.
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  // Model of the WB register contents.
  logic        m_valid;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_instret;

  mem_wb_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference load: shift the addressed lane down, mask it, extend by arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] word,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    longint lane;
    longint b;
    longint h;
    b = longint'((word >> (8 * int'(off))) & 32'hFF);
    lane = (off >= 2'd2) ? 1 : 0;
    h = longint'((word >> (16 * lane)) & 32'hFFFF);
    case (f3)
      3'd0:    return 32'((b > 127) ? b - 256 : b);
      3'd4:    return 32'(b);
      3'd1:    return 32'((h > 32767) ? h - 65536 : h);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb(input logic [1:0] mtr, input logic [2:0] f3,
                                         input logic [31:0] alu, input logic [31:0] pc4,
                                         input logic [31:0] word);
    if (mtr == 2'd1) return ref_load(word, f3, alu[1:0]);
    if (mtr == 2'd2) return pc4;
    return alu;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("wb_valid", 64'(bus.WbValid), 64'(m_valid));
    check("reg_write", 64'(bus.RegWrite), 64'(m_we));
    check("write_reg_num", 64'(bus.WriteRegNum), 64'(m_rd));
    check("write_reg_data", 64'(bus.WriteRegData), 64'(m_data));
`ifdef WB_INSTRET_EN
    check("instret", bus.Instret, m_instret);
`endif
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_we      = 1'b0;
    m_rd      = '0;
    m_data    = '0;
    m_instret = '0;
  endtask

  // Driver: one clock edge. The model advances from the inputs present at the edge.
  task automatic cycle();
    logic        n_valid;
    logic        n_we;
    logic [4:0]  n_rd;
    logic [31:0] n_data;
    logic [63:0] n_instret;
    n_valid = m_valid; n_we = m_we; n_rd = m_rd; n_data = m_data; n_instret = m_instret;
    if (bus.Flush) begin
      n_valid = 1'b0; n_we = 1'b0; n_rd = '0; n_data = '0;
    end else if (!bus.Stall) begin
      n_valid = bus.MemValid;
      n_rd    = bus.MemRd;
      n_we    = bus.MemValid && bus.MemRegWrite && (bus.MemRd != 5'd0);
      n_data  = ref_wb(bus.MemToReg, bus.MemFunct3, bus.MemAluResult,
                       bus.MemPcPlus4, bus.MemLoadWord);
      if (bus.MemValid) n_instret = m_instret + 64'd1;
    end
    @(posedge clk);
    m_valid = n_valid; m_we = n_we; m_rd = n_rd; m_data = n_data; m_instret = n_instret;
    #1;
    check_all();
  endtask

  task automatic drive(input logic valid, input logic we, input logic [4:0] rd,
                       input logic [1:0] mtr, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] word);
    bus.MemValid = valid; bus.MemRegWrite = we; bus.MemRd = rd; bus.MemToReg = mtr;
    bus.MemFunct3 = f3; bus.MemAluResult = alu; bus.MemPcPlus4 = pc4; bus.MemLoadWord = word;
  endtask

  task automatic drive_random();
    drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp);
    drive(1'b1, 1'b1, 5'd7, 2'b01, f3, {30'h0400_0000, off}, 32'h0, 32'h80FF7F01);
    cycle();
    check(tag, 64'(bus.WriteRegData), 64'(exp));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0);
    model_reset();
    #2;
    check_all();
    #6 rst = 1'b0;

    // ALU writeback.
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'd2, 32'h1234, 32'h100, 32'hDEAD_BEEF);
    cycle();
    check("alu_regwrite", 64'(bus.RegWrite), 64'd1);
    check("alu_rd", 64'(bus.WriteRegNum), 64'd5);
    check("alu_data", 64'(bus.WriteRegData), 64'h1234);

    // Load alignment and extension.
    load_case("lb_off3", 3'b000, 2'd3, 32'hFFFF_FF80);
    load_case("lbu_off1", 3'b100, 2'd1, 32'h0000_007F);
    load_case("lh_off2", 3'b001, 2'd2, 32'hFFFF_80FF);
    load_case("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
    load_case("lh_off3", 3'b001, 2'd3, 32'hFFFF_80FF);
    load_case("lw", 3'b010, 2'd1, 32'h80FF_7F01);
    load_case("undef_111", 3'b111, 2'd2, 32'h80FF_7F01);

    // Link value.
    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'd0, 32'h55, 32'h0000_2004, 32'h0);
    cycle();
    check("link_data", 64'(bus.WriteRegData), 64'h2004);

    // x0 is never written.
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'd0, 32'h77, 32'h0, 32'h0);
    cycle();
    check("x0_valid", 64'(bus.WbValid), 64'd1);
    check("x0_regwrite", 64'(bus.RegWrite), 64'd0);

    // Stall holds for three cycles while inputs change.
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
    cycle();
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      cycle();
      check("stall_hold_data", 64'(bus.WriteRegData), 64'hCAFE_0001);
    end

    // Flush with stall: bubble wins.
    bus.Flush = 1'b1;
    cycle();
    check("flush_valid", 64'(bus.WbValid), 64'd0);
    check("flush_regwrite", 64'(bus.RegWrite), 64'd0);
    bus.Flush = 1'b0;
    bus.Stall = 1'b0;

    // Bubble with MemRegWrite set does not write.
    drive(1'b0, 1'b1, 5'd12, 2'b00, 3'd0, 32'h9, 32'h0, 32'h0);
    cycle();
    check("bubble_regwrite", 64'(bus.RegWrite), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bus.Stall = ($urandom_range(0, 4) == 0);
      bus.Flush = ($urandom_range(0, 9) == 0);
      drive_random();
      cycle();
    end
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;

    // Asynchronous reset mid-cycle drops the pending write immediately.
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'd0, 32'hABCD, 32'h0, 32'h0);
    cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    #1 rst = 1'b0;

`ifdef WB_INSTRET_EN
    // Retired count: 10 loaded, 2 stalled, 1 flushed, 1 bubble.
    for (int i = 0; i < 10; i++) begin
      drive_random();
      bus.MemValid = 1'b1;
      cycle();
    end
    bus.Stall = 1'b1;
    cycle();
    cycle();
    bus.Stall = 1'b0;
    bus.Flush = 1'b1;
    cycle();
    bus.Flush = 1'b0;
    bus.MemValid = 1'b0;
    cycle();
    check("instret_10", bus.Instret, 64'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
